// File: rtl/step_ramp_ctrl.sv
// Step/ramp move sequencer feeding pul_generate: trapezoidal period profile with abort.
// Optional STEP_POS_CNT_EN adds a signed position counter with pos_clr.
module step_ramp_ctrl #(
    parameter int CNT_W = 32,
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic [PER_W-1:0] cmd_per_start,
    input  logic [PER_W-1:0] cmd_per_min,
    input  logic [PER_W-1:0] cmd_per_dec,
    input  logic             abort,
    output logic             pg_start,
    output logic [31:0]      pg_pul_data,
    input  logic             pg_done,
    output logic             dir_out,
    output logic             busy,
    output logic [CNT_W-1:0] steps_left,
    output logic             move_done,
`ifdef STEP_POS_CNT_EN
    input  logic             pos_clr,
    output logic signed [31:0] position,
`endif
    output logic             aborted
);

    typedef enum logic [2:0] {
        IDLE, ACCEL, CRUISE, DECEL, STOP
    } state_t;

    state_t state;
    logic [PER_W-1:0] cur_per, pmin_q, pst_q, dec_q;
    logic [CNT_W-1:0] remaining, rc;

    logic [PER_W-1:0] acc_pmin, acc_pst;
    logic             done_ok;
    logic [CNT_W-1:0] rem_dn, rc_inc, rc_dn;
    logic [PER_W:0]   acc_diff, cru_up, dec_up, abt_up;
    logic             acc_floor;
    logic [PER_W-1:0] cru_per, dec_per, abt_per;

    state_t           u_state, n_state;
    logic [CNT_W-1:0] u_rem, u_rc, n_rem, n_rc;
    logic [PER_W-1:0] u_per, n_per;
    logic             abt;

    assign cmd_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign steps_left  = remaining;
    assign pg_pul_data = 32'(cur_per);

    // Clamp the command so the generator never sees a period below 2.
    always_comb begin
        acc_pmin = (cmd_per_min < PER_W'(2)) ? PER_W'(2) : cmd_per_min;
        acc_pst  = (cmd_per_start < acc_pmin) ? acc_pmin : cmd_per_start;
    end

    always_comb begin
        done_ok   = pg_done && (state == ACCEL || state == CRUISE
                                || state == DECEL);
        rem_dn    = (remaining == '0) ? '0 : remaining - 1'b1;
        rc_inc    = rc + 1'b1;
        rc_dn     = (rc == '0) ? '0 : rc - 1'b1;
        acc_diff  = {1'b0, cur_per} - {1'b0, dec_q};
        acc_floor = acc_diff[PER_W] || (acc_diff[PER_W-1:0] <= pmin_q);
        cru_up    = {1'b0, pmin_q} + {1'b0, dec_q};
        dec_up    = {1'b0, cur_per} + {1'b0, dec_q};
        cru_per   = (cru_up > {1'b0, pst_q}) ? pst_q : cru_up[PER_W-1:0];
        dec_per   = (dec_up > {1'b0, pst_q}) ? pst_q : dec_up[PER_W-1:0];
    end

    // Step update first; abort is then judged against the updated values.
    always_comb begin
        u_state = state;
        u_rem   = remaining;
        u_rc    = rc;
        u_per   = cur_per;
        if (done_ok) begin
            u_rem = rem_dn;
            case (state)
                ACCEL: begin
                    u_rc = rc_inc;
                    if (rem_dn <= rc_inc) begin
                        u_state = DECEL;
                    end else if (acc_floor) begin
                        u_per   = pmin_q;
                        u_state = CRUISE;
                    end else begin
                        u_per = acc_diff[PER_W-1:0];
                    end
                end
                CRUISE: begin
                    if (rem_dn <= rc) begin
                        u_state = DECEL;
                        u_per   = cru_per;
                        u_rc    = rc_dn;
                    end
                end
                DECEL: begin
                    u_per = dec_per;
                    u_rc  = rc_dn;
                end
                default: ;
            endcase
            if (rem_dn == '0)
                u_state = STOP;
        end
    end

    always_comb begin
        abt_up  = {1'b0, u_per} + {1'b0, dec_q};
        abt_per = (abt_up > {1'b0, pst_q}) ? pst_q : abt_up[PER_W-1:0];
        n_state = u_state;
        n_rem   = u_rem;
        n_rc    = u_rc;
        n_per   = u_per;
        abt     = 1'b0;
        if (abort && (u_state == ACCEL || u_state == CRUISE)
            && (u_rc < u_rem)) begin
            abt   = 1'b1;
            n_rem = u_rc;
            if (u_rc == '0) begin
                n_state = STOP;
            end else begin
                n_state = DECEL;
                // Period may only move on a step boundary.
                if (done_ok) begin
                    n_per = abt_per;
                    n_rc  = u_rc - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur_per   <= '0;
            pmin_q    <= '0;
            pst_q     <= '0;
            dec_q     <= '0;
            remaining <= '0;
            rc        <= '0;
            pg_start  <= 1'b0;
            dir_out   <= 1'b0;
            move_done <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            move_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        pmin_q    <= acc_pmin;
                        pst_q     <= acc_pst;
                        dec_q     <= cmd_per_dec;
                        cur_per   <= acc_pst;
                        remaining <= cmd_steps;
                        rc        <= '0;
                        dir_out   <= cmd_dir;
                        aborted   <= 1'b0;
                        pg_start  <= (cmd_steps != '0);
                        if (cmd_steps == '0)
                            state <= STOP;
                        else if (acc_pst > acc_pmin)
                            state <= ACCEL;
                        else
                            state <= CRUISE;
                    end
                end
                STOP: begin
                    pg_start  <= 1'b0;
                    state     <= IDLE;
                    move_done <= 1'b1;
                end
                default: begin
                    state     <= n_state;
                    remaining <= n_rem;
                    rc        <= n_rc;
                    cur_per   <= n_per;
                    if (abt)
                        aborted <= 1'b1;
                    if (n_state == STOP)
                        pg_start <= 1'b0;
                end
            endcase
        end
    end

`ifdef STEP_POS_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            position <= '0;
        else if (pos_clr)
            position <= '0;
        else if (done_ok)
            position <= dir_out ? position + 32'sd1 : position - 32'sd1;
    end
`endif

endmodule
